// File: rtl/digital_gates.sv
// digital_gates: two-input gate demonstrator; live gate vector on uo_out, snapshot on uio_out
module digital_gates (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic       a;
  logic       b;
  logic [7:0] g;
  logic       unused_ok;
  assign a = ui_in[0];
  assign b = ui_in[1];
  assign g = {~b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
  assign uo_out = g;
  assign uio_oe = 8'hff;
  assign unused_ok = &{1'b0, ui_in[7:2], uio_in};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) uio_out <= 8'h00;
    else if (ena) uio_out <= g;
endmodule

// File: tb/tb_digital_gates.sv
// tb_digital_gates: randomized scoreboard bench for digital_gates against a truth-table model
module tb_digital_gates;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    string      name;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t       sb[$];
  event       chk;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mreg;

  digital_gates dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Each gate is a 4-entry truth table indexed by {A,B}
  function automatic logic [7:0] model(input logic [7:0] ui);
    logic [3:0] tt [8];
    logic [7:0] r;
    int         idx;
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b0101};
    idx = ui[0] * 2 + ui[1];
    for (int k = 0; k < 8; k++) r[k] = tt[k][idx];
    return r;
  endfunction

  task automatic expect_now(input string name);
    exp_t e;
    e.name = name;
    e.uo = model(ui_in);
    e.uio = mreg;
    sb.push_back(e);
    ->chk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && ena) mreg = model(ui_in);
    #1;
  endtask

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) mreg = 8'h00;
  endtask

  initial forever begin
    @(chk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 3;
      if (uo_out !== e.uo) begin
        failures++;
        $display("FAIL %s uo_out got=%h exp=%h", e.name, uo_out, e.uo);
      end
      if (uio_out !== e.uio) begin
        failures++;
        $display("FAIL %s uio_out got=%h exp=%h", e.name, uio_out, e.uio);
      end
      if (uio_oe !== 8'hff) begin
        failures++;
        $display("FAIL %s uio_oe got=%h exp=ff", e.name, uio_oe);
      end
    end
  end

  initial begin
    ena = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h00;
    set_rst(1'b0);
    #3;
    expect_now("reset_ab00");
    uio_in = 8'($urandom);
    ui_in = 8'hfc & 8'($urandom);
    #1;
    expect_now("reset_noise");
    ui_in = 8'h03;
    #1;
    expect_now("reset_ab11_live");
    tick();
    expect_now("reset_hold");
    @(negedge clk);
    set_rst(1'b1);
    ena = 1'b1;
    for (int v = 0; v < 4; v++) begin
      ui_in = {6'b0, v[0], v[1]};
      #1;
      expect_now("vec_comb");
      tick();
      expect_now("vec_capture");
    end
    ena = 1'b0;
    ui_in = 8'h00;
    #1;
    expect_now("ena0_comb");
    tick();
    expect_now("ena0_hold1");
    tick();
    expect_now("ena0_hold2");
    ena = 1'b1;
    ui_in = 8'h02;
    tick();
    expect_now("pre_async");
    #2;
    set_rst(1'b0);
    #1;
    expect_now("async_clear");
    ui_in = 8'h01;
    #1;
    expect_now("reset_tracks");
    tick();
    expect_now("reset_edge_hold");
    #2;
    set_rst(1'b1);
    tick();
    expect_now("first_capture");
    for (int i = 0; i < 20; i++) begin
      ui_in = {6'($urandom), 2'b01};
      uio_in = 8'($urandom);
      #1;
      expect_now("noise_comb");
      tick();
      expect_now("noise_capture");
    end
    for (int i = 0; i < 60; i++) begin
      ui_in = 8'($urandom);
      uio_in = 8'($urandom);
      ena = 1'($urandom);
      if ($urandom_range(9) == 0) set_rst(1'b0);
      else if (!rst_n) set_rst(1'b1);
      #1;
      expect_now("rand_comb");
      tick();
      expect_now("rand_edge");
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
